// File: rtl/lsu_pkg.sv
// Shared load-unit types: controller state encoding, funct3 load-width codes
// and the alignment rule used at accept time.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    FAULT
  } load_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Undecoded width codes report as misaligned so they never reach memory.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: is_misaligned = 1'b0;
      F3_LH, F3_LHU: is_misaligned = off[0];
      F3_LW:         is_misaligned = (off != 2'b00);
      default:       is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Byte/halfword lane select with sign or zero extension for sub-word loads.
module load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            byte_off,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_in[{byte_off, 3'b000} +: 8];
    half_sel = data_in[{byte_off[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data_out = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_out = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LH:   data_out = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_out = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Memory-load stage: effective address, one read transaction, write-back strobe.
// Optional LOAD_SUBWORD_EN enables LB/LH/LBU/LHU decoding via load_align.
module load_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [DATA_WIDTH-1:0]     base,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [2:0]                funct3,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      misaligned,
  output logic [ADDR_WIDTH-1:0]     fault_addr
);

  load_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]     sum;
  logic [ADDR_WIDTH-1:0]     ea;
  logic                      ea_mis;
  logic                      accept;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [DATA_WIDTH-1:0]     load_data;
  logic                      unused_ok;

  assign sum    = base + imm;
  assign ea     = sum[ADDR_WIDTH-1:0];
  assign accept = start_valid && (state_q == IDLE);

`ifdef LOAD_SUBWORD_EN
  logic [2:0] f3_q;

  assign ea_mis = is_misaligned(funct3, ea[1:0]);

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3   (f3_q),
    .byte_off (addr_q[1:0]),
    .data_in  (data_q),
    .data_out (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      f3_q <= '0;
    else if (accept) f3_q <= funct3;
  end
`else
  assign ea_mis    = (ea[1:0] != 2'b00);
  assign load_data = data_q;
`endif

  assign unused_ok = ^{sum, addr_q[1:0], funct3};

  always_comb begin
    state_d       = state_q;
    start_ready   = 1'b0;
    mem_req_valid = 1'b0;
    wb_valid      = 1'b0;
    misaligned    = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_d = ea_mis ? FAULT : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) state_d = RESP;
      end
      RESP: begin
        wb_valid = 1'b1;
        state_d  = IDLE;
      end
      FAULT: begin
        misaligned = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to zero outside their qualifying strobe.
  assign mem_addr = mem_req_valid ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign wb_rd    = wb_valid ? rd_q : '0;
  assign wb_data  = wb_valid ? load_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_q       <= '0;
      data_q     <= '0;
      fault_addr <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= ea;
        rd_q       <= rd_addr;
        fault_addr <= ea_mis ? ea : '0;
      end
      if ((state_q == WAIT) && mem_rsp_valid) data_q <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_load_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [DW-1:0] base = '0;
  logic [DW-1:0] imm = '0;
  logic [2:0]    funct3 = 3'b010;
  logic [RW-1:0] rd_addr = '0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          misaligned;
  logic [AW-1:0] fault_addr;

  load_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .base(base), .imm(imm), .funct3(funct3), .rd_addr(rd_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misaligned(misaligned), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit mis_rule(input logic [2:0] f3, input longint a);
`ifdef LOAD_SUBWORD_EN
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return (a % 2) != 0;
      3'b010:         return (a % 4) != 0;
      default:        return 1'b1;
    endcase
`else
    return (a % 4) != 0;
`endif
  endfunction

  function automatic logic [DW-1:0] extract(input logic [2:0] f3, input longint a,
                                             input logic [DW-1:0] d);
`ifdef LOAD_SUBWORD_EN
    longint b, h;
    b = (longint'(d) >> (8 * (a % 4))) & 255;
    h = (longint'(d) >> (16 * ((a % 4) / 2))) & 65535;
    case (f3)
      3'b000: return (b >= 128) ? DW'(b - 256) : DW'(b);
      3'b100: return DW'(b);
      3'b001: return (h >= 32768) ? DW'(h - 65536) : DW'(h);
      3'b101: return DW'(h);
      default: return d;
    endcase
`else
    return d;
`endif
  endfunction

  bit            m_req, m_wait, m_wb, m_fault, m_fa_known;
  bit            n_req, n_wait, n_wb, n_fault, m_idle;
  longint        m_addr, m_ea;
  logic [RW-1:0] m_rd;
  logic [2:0]    m_f3;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_fa;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 0; m_wait = 0; m_wb = 0; m_fault = 0; m_fa_known = 0;
    end else begin
      m_idle  = !(m_req || m_wait || m_wb || m_fault);
      n_req   = m_req; n_wait = m_wait;
      n_wb    = 0;     n_fault = 0;
      if (m_wait && mem_rsp_valid) begin
        n_wait = 0; n_wb = 1;
        m_data = extract(m_f3, m_addr, mem_rsp_data);
      end
      if (m_req && mem_req_ready) begin
        n_req = 0; n_wait = 1;
      end
      if (m_idle && start_valid) begin
        m_ea   = (longint'(base) + longint'(imm)) % (64'sd1 <<< AW);
        m_addr = m_ea; m_rd = rd_addr; m_f3 = funct3;
        if (mis_rule(funct3, m_ea)) begin
          n_fault = 1; m_fa = AW'(m_ea); m_fa_known = 1;
        end else begin
          n_req = 1; m_fa_known = 0;
        end
      end
      m_req = n_req; m_wait = n_wait; m_wb = n_wb; m_fault = n_fault;
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  int cyc = 0, acc_cyc = 0, wb_cyc = 0, mis_cyc = 0;
  int wb_cnt = 0, mis_cnt = 0, req_cnt = 0, addr_changes = 0;
  logic [DW-1:0] last_wb_data;
  logic [RW-1:0] last_wb_rd;
  logic [AW-1:0] last_req_addr, last_fa;
  bit prev_req = 0;

  always @(negedge clk) begin
    cyc++;
    cmp("start_ready", start_ready, !(m_req || m_wait || m_wb || m_fault));
    cmp("mem_req_valid", mem_req_valid, m_req);
    cmp("mem_addr", mem_addr, m_req ? (m_addr / 4) * 4 : 0);
    cmp("wb_valid", wb_valid, m_wb);
    cmp("wb_rd", wb_rd, m_wb ? m_rd : 0);
    cmp("wb_data", wb_data, m_wb ? m_data : 0);
    cmp("misaligned", misaligned, m_fault);
    if (m_fa_known) cmp("fault_addr", fault_addr, m_fa);
    if (start_valid && start_ready) acc_cyc = cyc;
    if (wb_valid) begin
      wb_cnt++; wb_cyc = cyc; last_wb_data = wb_data; last_wb_rd = wb_rd;
    end
    if (misaligned) begin
      mis_cnt++; mis_cyc = cyc; last_fa = fault_addr;
    end
    if (mem_req_valid) begin
      if (prev_req && mem_addr != last_req_addr) addr_changes++;
      req_cnt++; last_req_addr = mem_addr;
    end
    prev_req = mem_req_valid;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wb_cnt = 0; mis_cnt = 0; req_cnt = 0; addr_changes = 0;
  endtask

  task automatic issue(input logic [DW-1:0] b, input logic [DW-1:0] i,
                       input logic [2:0] f3, input logic [RW-1:0] rd);
    clear_log();
    start_valid = 1; base = b; imm = i; funct3 = f3; rd_addr = rd;
    tick();
    start_valid = 0; base = '0; imm = '0; rd_addr = '0;
  endtask

  task automatic load_seq(input logic [DW-1:0] b, input logic [DW-1:0] i,
                          input logic [2:0] f3, input logic [RW-1:0] rd,
                          input int rdy_wait, input int rsp_wait,
                          input logic [DW-1:0] data);
    issue(b, i, f3, rd);
    repeat (rdy_wait) tick();
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    repeat (rsp_wait) tick();
    mem_rsp_valid = 1; mem_rsp_data = data; tick();
    mem_rsp_valid = 0; mem_rsp_data = '0;
    repeat (2) tick();
  endtask

  task automatic fault_seq(input logic [DW-1:0] b, input logic [DW-1:0] i,
                           input logic [2:0] f3);
    issue(b, i, f3, 5'd3);
    repeat (3) tick();
    cmp("fault_pulses", mis_cnt, 1);
    cmp("fault_latency", mis_cyc - acc_cyc, 1);
    cmp("fault_no_req", req_cnt, 0);
    cmp("fault_no_wb", wb_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    cmp("reset_start_ready", start_ready, 1);
    cmp("reset_mem_req_valid", mem_req_valid, 0);
    cmp("reset_wb_valid", wb_valid, 0);
    cmp("reset_fault_addr", fault_addr, 0);
    rst_n = 1;
    tick();

    load_seq(32'h1000, 32'h10, 3'b010, 5'd5, 0, 0, 32'hDEADBEEF);
    cmp("basic_addr", last_req_addr, 32'h1010);
    cmp("basic_latency", wb_cyc - acc_cyc, 3);
    cmp("basic_wb_cnt", wb_cnt, 1);
    cmp("basic_wb_rd", last_wb_rd, 5);
    cmp("basic_wb_data", last_wb_data, 32'hDEADBEEF);

    load_seq(32'h1000, 32'hFFFFFFFC, 3'b010, 5'd7, 0, 1, 32'h12345678);
    cmp("neg_imm_addr", last_req_addr, 32'h0FFC);
    cmp("neg_imm_data", last_wb_data, 32'h12345678);

    load_seq(32'hFFFFFFFC, 32'h8, 3'b010, 5'd9, 0, 0, 32'hA5A5A5A5);
    cmp("wrap_addr", last_req_addr, 32'h4);

    fault_seq(32'h1002, 32'h0, 3'b010);
    cmp("fault_addr_lit", last_fa, 32'h1002);

    load_seq(32'h3000, 32'h20, 3'b010, 5'd12, 3, 4, 32'hCAFEF00D);
    cmp("stall_addr_stable", addr_changes, 0);
    cmp("stall_req_cycles", req_cnt, 4);
    cmp("stall_wb_cnt", wb_cnt, 1);
    cmp("stall_wb_data", last_wb_data, 32'hCAFEF00D);

    load_seq(32'h40, 32'h0, 3'b010, 5'd0, 0, 0, 32'h11112222);
    cmp("rd0_wb_cnt", wb_cnt, 1);
    cmp("rd0_wb_rd", last_wb_rd, 0);

    clear_log();
    mem_rsp_valid = 1; mem_rsp_data = 32'h99999999; tick();
    mem_rsp_valid = 0; mem_rsp_data = '0; repeat (2) tick();
    cmp("idle_rsp_dropped", wb_cnt, 0);

    issue(32'h5000, 32'h4, 3'b010, 5'd6);
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    tick();
    rst_n = 0; tick();
    rst_n = 1;
    mem_rsp_valid = 1; mem_rsp_data = 32'h77777777; tick();
    mem_rsp_valid = 0; mem_rsp_data = '0; repeat (2) tick();
    cmp("rst_wait_no_wb", wb_cnt, 0);
    cmp("rst_wait_ready", start_ready, 1);

`ifdef LOAD_SUBWORD_EN
    load_seq(32'h2000, 32'h3, 3'b000, 5'd1, 0, 0, 32'h80FFFFFF);
    cmp("lb_data", last_wb_data, 32'hFFFFFF80);
    load_seq(32'h2000, 32'h3, 3'b100, 5'd2, 0, 0, 32'h80FFFFFF);
    cmp("lbu_data", last_wb_data, 32'h00000080);
    load_seq(32'h2000, 32'h2, 3'b001, 5'd3, 0, 0, 32'h80011234);
    cmp("lh_data", last_wb_data, 32'hFFFF8001);
    load_seq(32'h2000, 32'h2, 3'b101, 5'd4, 0, 0, 32'h80011234);
    cmp("lhu_data", last_wb_data, 32'h00008001);
    fault_seq(32'h2000, 32'h1, 3'b001);
    cmp("lh_fault_addr", last_fa, 32'h2001);
    fault_seq(32'h2000, 32'h0, 3'b011);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
